// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the streaming 1-D convolution engine.
//   state_t   : engine phase (LOAD, COMPUTE, DRAIN)
//   sat_t     : clamp a wide signed value to a w-bit signed range (w <= 32)
//   op_count  : outputs per frame for a valid, stride-1 convolution
//   grp_count : compute passes per frame, ceil(op_count / P)
package conv1d_pkg;

    localparam int unsigned T_DEF       = 16;
    localparam int unsigned X_COUNT_DEF = 16;
    localparam int unsigned F_COUNT_DEF = 8;
    localparam int unsigned P_DEF       = 1;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    function automatic longint sat_t(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - longint'(1);
        lo = -hi - longint'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int unsigned op_count(input int unsigned xc, input int unsigned fc);
        return xc - fc + 1;
    endfunction

    function automatic int unsigned grp_count(input int unsigned oc, input int unsigned p);
        return (oc + p - 1) / p;
    endfunction

endpackage

// File: rtl/conv1d_mac_lane.sv
// One MAC lane: registered saturating multiply feeding a saturating accumulator.
// Ports:
//   clk, rst_n : clock, async active-low reset (already synchronised)
//   clr_i      : zero the accumulator and flush the product stage
//   en_i       : x_i/f_i carry a valid tap pair this cycle
//   x_i, f_i   : signed operands from the shared memory read stage
//   acc_c      : accumulator value after this cycle's update (next-state view)
module conv1d_mac_lane
    import conv1d_pkg::*;
#(
    parameter int unsigned T = T_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [T-1:0] x_i,
    input  logic [T-1:0] f_i,
    output logic [T-1:0] acc_c
);

    logic signed [2*T-1:0] prod_full;
    logic signed [T:0]     sum_c;
    logic [T-1:0]          prod_q;
    logic                  pv_q;
    logic [T-1:0]          acc_q;

    assign prod_full = $signed(x_i) * $signed(f_i);

    // Widen by one bit so the add cannot wrap before the clamp.
    always_comb begin
        sum_c = $signed({acc_q[T-1], acc_q}) + $signed({prod_q[T-1], prod_q});
        acc_c = acc_q;
        if (clr_i) begin
            acc_c = '0;
        end else if (pv_q) begin
            acc_c = T'(sat_t(longint'(sum_c), T));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc_q  <= '0;
        end else begin
            acc_q <= acc_c;
            if (clr_i) begin
                prod_q <= '0;
                pv_q   <= 1'b0;
            end else begin
                prod_q <= T'(sat_t(longint'(prod_full), T));
                pv_q   <= en_i;
            end
        end
    end

endmodule

// File: rtl/conv1d_stream_par.sv
// Streaming 1-D valid convolution (stride 1) with a runtime-loaded filter.
// x and f frames are loaded over two valid/ready slave streams, P MAC lanes
// compute one output each per pass, results leave on a valid/ready master.
// Ports:
//   clk, reset                       : clock, async active-low reset
//   s_data_in_x/s_valid_x/s_ready_x  : input sample stream
//   s_data_in_f/s_valid_f/s_ready_f  : filter tap stream, tap 0 first
//   m_data_out_y/m_valid_y/m_ready_y : output stream, y[0] first
// Build option: define CONV1D_RELU_EN to clamp emitted values at zero.
module conv1d_stream_par
    import conv1d_pkg::*;
#(
    parameter int unsigned T       = T_DEF,
    parameter int unsigned X_COUNT = X_COUNT_DEF,
    parameter int unsigned F_COUNT = F_COUNT_DEF,
    parameter int unsigned P       = P_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] s_data_in_x,
    input  logic         s_valid_x,
    output logic         s_ready_x,
    input  logic [T-1:0] s_data_in_f,
    input  logic         s_valid_f,
    output logic         s_ready_f,
    output logic [T-1:0] m_data_out_y,
    output logic         m_valid_y,
    input  logic         m_ready_y
);

    localparam int unsigned OP_COUNT = op_count(X_COUNT, F_COUNT);
    localparam int unsigned GROUPS   = grp_count(OP_COUNT, P);
    localparam int unsigned LAST_P   = OP_COUNT - (GROUPS - 1) * P;
    localparam int unsigned XW       = $clog2(X_COUNT);
    localparam int unsigned FW       = $clog2(F_COUNT);
    localparam int unsigned CW       = $clog2(F_COUNT + 2);
    localparam int unsigned GW       = $clog2(GROUPS + 1);
    localparam int unsigned LW       = $clog2(P + 1);
    localparam int unsigned BW       = $clog2(X_COUNT + P + F_COUNT + 2);

    // Release of reset is retimed to clk; assertion stays asynchronous.
    logic [1:0] rsync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rsync_q <= 2'b00;
        else        rsync_q <= {rsync_q[0], 1'b1};
    end
    assign rst_n = rsync_q[1];

    state_t        state_q;
    logic          rdy_x_q, rdy_f_q;
    logic [XW-1:0] wx_q;
    logic [FW-1:0] wf_q;
    logic [CW-1:0] c_q;
    logic [GW-1:0] g_q;
    logic [BW-1:0] base_q;
    logic [LW-1:0] ln_q;
    logic          clr_q;
    logic          rd_v_q;
    logic          valid_q;
    logic [T-1:0]  data_q;

    logic [T-1:0]  x_mem [X_COUNT];
    logic [T-1:0]  f_mem [F_COUNT];
    logic [T-1:0]  f_rd_q;
    logic [T-1:0]  x_rd_q [P];
    logic [BW-1:0] xa [P];
    logic [T-1:0]  acc_nxt_w [P];
    logic [T-1:0]  lane_nxt;
    logic [LW-1:0] last_ln;
    logic          wr_x, wr_f;

    assign wr_x = (state_q == LOAD) && rdy_x_q && s_valid_x;
    assign wr_f = (state_q == LOAD) && rdy_f_q && s_valid_f;

    assign last_ln = (g_q == GW'(GROUPS - 1)) ? LW'(LAST_P - 1) : LW'(P - 1);

    function automatic logic [T-1:0] out_map(input logic [T-1:0] y);
`ifdef CONV1D_RELU_EN
        return y[T-1] ? '0 : y;
`else
        return y;
`endif
    endfunction

    // Lane k reads x at base + k + tap; addresses past the frame only feed discarded lanes.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            xa[k] = base_q + BW'(k) + BW'(c_q);
        end
    end

    // Value of the lane after the one currently presented.
    always_comb begin
        lane_nxt = '0;
        for (int k = 0; k < P; k++) begin
            if (LW'(k) == ln_q + LW'(1)) lane_nxt = acc_nxt_w[k];
        end
    end

    // Frame memories and the shared one-cycle read stage.
    always_ff @(posedge clk) begin
        if (wr_x) x_mem[wx_q] <= s_data_in_x;
        if (wr_f) f_mem[wf_q] <= s_data_in_f;
        f_rd_q <= (c_q < CW'(F_COUNT)) ? f_mem[FW'(c_q)] : '0;
        for (int k = 0; k < P; k++) begin
            x_rd_q[k] <= (xa[k] < BW'(X_COUNT)) ? x_mem[XW'(xa[k])] : '0;
        end
    end

    for (genvar k = 0; k < P; k++) begin : g_lane
        conv1d_mac_lane #(.T(T)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr_q),
            .en_i  (rd_v_q),
            .x_i   (x_rd_q[k]),
            .f_i   (f_rd_q),
            .acc_c (acc_nxt_w[k])
        );
    end

    // Engine FSM with registered stream controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            rdy_x_q <= 1'b1;
            rdy_f_q <= 1'b1;
            wx_q    <= '0;
            wf_q    <= '0;
            c_q     <= '0;
            g_q     <= '0;
            base_q  <= '0;
            ln_q    <= '0;
            clr_q   <= 1'b0;
            rd_v_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            clr_q  <= 1'b0;
            rd_v_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (wr_x) begin
                        if (wx_q == XW'(X_COUNT - 1)) rdy_x_q <= 1'b0;
                        else                          wx_q    <= wx_q + XW'(1);
                    end
                    if (wr_f) begin
                        if (wf_q == FW'(F_COUNT - 1)) rdy_f_q <= 1'b0;
                        else                          wf_q    <= wf_q + FW'(1);
                    end
                    if (!rdy_x_q && !rdy_f_q) begin
                        state_q <= COMPUTE;
                        clr_q   <= 1'b1;
                        c_q     <= '0;
                        g_q     <= '0;
                        base_q  <= '0;
                        wx_q    <= '0;
                        wf_q    <= '0;
                    end
                end
                COMPUTE: begin
                    rd_v_q <= (c_q < CW'(F_COUNT));
                    // Last cycle: the final add lands on this edge, so present lane 0's next value.
                    if (c_q == CW'(F_COUNT + 1)) begin
                        state_q <= DRAIN;
                        ln_q    <= '0;
                        valid_q <= 1'b1;
                        data_q  <= out_map(acc_nxt_w[0]);
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (valid_q && m_ready_y) begin
                        if (ln_q == last_ln) begin
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            if (g_q == GW'(GROUPS - 1)) begin
                                state_q <= LOAD;
                                rdy_x_q <= 1'b1;
                                rdy_f_q <= 1'b1;
                            end else begin
                                state_q <= COMPUTE;
                                clr_q   <= 1'b1;
                                c_q     <= '0;
                                g_q     <= g_q + GW'(1);
                                base_q  <= base_q + BW'(P);
                            end
                        end else begin
                            ln_q   <= ln_q + LW'(1);
                            data_q <= out_map(lane_nxt);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign s_ready_x    = rdy_x_q;
    assign s_ready_f    = rdy_f_q;
    assign m_valid_y    = valid_q;
    assign m_data_out_y = data_q;

endmodule

// File: tb/tb_conv1d_stream_par.sv
module tb_conv1d_stream_par;

    logic        clk;
    logic        reset;
    logic [15:0] sdx [2];
    logic        svx [2];
    logic        srx [2];
    logic [15:0] sdf [2];
    logic        svf [2];
    logic        srf [2];
    logic [15:0] my  [2];
    logic        mv  [2];
    logic        mr  [2];

    int errors = 0;
    int checks = 0;

    conv1d_stream_par #(.P(1)) dut (
        .clk(clk), .reset(reset),
        .s_data_in_x(sdx[0]), .s_valid_x(svx[0]), .s_ready_x(srx[0]),
        .s_data_in_f(sdf[0]), .s_valid_f(svf[0]), .s_ready_f(srf[0]),
        .m_data_out_y(my[0]), .m_valid_y(mv[0]), .m_ready_y(mr[0])
    );

    conv1d_stream_par #(.P(4)) dut4 (
        .clk(clk), .reset(reset),
        .s_data_in_x(sdx[1]), .s_valid_x(svx[1]), .s_ready_x(srx[1]),
        .s_data_in_f(sdf[1]), .s_valid_f(svf[1]), .s_ready_f(srf[1]),
        .m_data_out_y(my[1]), .m_valid_y(mv[1]), .m_ready_y(mr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference convolution with saturating product and accumulator.
    function automatic logic [15:0] gold(input logic [15:0] xv[16], input logic [15:0] fv[8], input int j);
        longint acc;
        longint p;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            p = longint'($signed(xv[j + i])) * longint'($signed(fv[i]));
            if (p > 32767)  p = 32767;
            if (p < -32768) p = -32768;
            acc = acc + p;
            if (acc > 32767)  acc = 32767;
            if (acc < -32768) acc = -32768;
        end
`ifdef CONV1D_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return 16'(acc);
    endfunction

    task automatic load_frame(input int d, input logic [15:0] xv[16], input logic [15:0] fv[8],
                              input bit stall, input bit f_first);
        int xi, fi, guard;
        bit wx, wf, rx, rf;
        xi = 0; fi = 0; guard = 0;
        while ((xi < 16 || fi < 8) && guard < 400) begin
            @(negedge clk);
            wx = (xi < 16) && !(f_first && fi < 8) && !(stall && $urandom_range(0, 2) == 0);
            wf = (fi < 8) && !(stall && $urandom_range(0, 2) == 0);
            svx[d] = wx;
            sdx[d] = wx ? xv[xi] : 16'h0;
            svf[d] = wf;
            sdf[d] = wf ? fv[fi] : 16'h0;
            rx = srx[d];
            rf = srf[d];
            @(posedge clk);
            if (wx && rx) xi++;
            if (wf && rf) fi++;
            guard++;
        end
        checks++;
        if (xi != 16 || fi != 8) begin
            errors++;
            $display("FAIL load_done dut%0d: x words=%0d f words=%0d, required 16 and 8", d, xi, fi);
        end
    endtask

    task automatic collect(input int d, input int n, input int mode, output logic [15:0] got[16],
                           output int cnt, output int cyc_last, output bit rdy_last);
        int cyc;
        bit pv, pr, v, r;
        logic [15:0] pd, dd;
        cnt = 0; cyc = 0; pv = 0; pr = 0; pd = 0; rdy_last = 0; cyc_last = 0;
        for (int j = 0; j < 16; j++) got[j] = 16'h0;
        while (cnt < n && cyc < 3000) begin
            @(negedge clk);
            svx[d] = 1'b0;
            svf[d] = 1'b0;
            r = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            mr[d] = r;
            v  = mv[d];
            dd = my[d];
            if (pv && !pr) begin
                checks++;
                if (!v || dd !== pd) begin
                    errors++;
                    $display("FAIL stall_hold dut%0d: valid=%0b data=%h, required valid=1 data=%h", d, v, dd, pd);
                end
            end
            if (!v) begin
                checks++;
                if (dd !== 16'h0) begin
                    errors++;
                    $display("FAIL idle_data dut%0d: data=%h while invalid, required 0000", d, dd);
                end
            end
            if (v && r) rdy_last = srx[d] | srf[d];
            pv = v; pr = r; pd = dd;
            @(posedge clk);
            cyc++;
            if (v && r) begin
                got[cnt] = dd;
                cnt++;
                cyc_last = cyc;
            end
        end
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL collect_count dut%0d: got %0d outputs, required %0d", d, cnt, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (srx[d] !== 1'b1 || srf[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready dut%0d: x=%0b f=%0b, required 1 1", d, srx[d], srf[d]);
            end
            checks++;
            if (mv[d] !== 1'b0 || my[d] !== 16'h0) begin
                errors++;
                $display("FAIL reset_out dut%0d: valid=%0b data=%h, required 0 0000", d, mv[d], my[d]);
            end
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ramp_p1();
        logic [15:0] xv[16], fv[8], got[16], exp1[9];
        int cnt, cl;
        bit rl;
        exp1 = '{16'd36, 16'd44, 16'd52, 16'd60, 16'd68, 16'd76, 16'd84, 16'd92, 16'd100};
        for (int i = 0; i < 16; i++) xv[i] = 16'(i + 1);
        for (int i = 0; i < 8; i++)  fv[i] = 16'd1;
        load_frame(0, xv, fv, 1'b0, 1'b0);
        collect(0, 9, 0, got, cnt, cl, rl);
        for (int j = 0; j < 9; j++) begin
            checks++;
            if (got[j] !== exp1[j]) begin
                errors++;
                $display("FAIL ramp_p1[%0d]: got %0d, required %0d", j, got[j], exp1[j]);
            end
        end
        checks++;
        if (cl < 97 || cl > 101) begin
            errors++;
            $display("FAIL ramp_p1_latency: %0d cycles, required 99 +/- 2", cl);
        end
    endtask

    task automatic test_ramp_p4();
        logic [15:0] xv[16], fv[8], got[16], exp1[9];
        int cnt, cl;
        bit rl;
        exp1 = '{16'd36, 16'd44, 16'd52, 16'd60, 16'd68, 16'd76, 16'd84, 16'd92, 16'd100};
        for (int i = 0; i < 16; i++) xv[i] = 16'(i + 1);
        for (int i = 0; i < 8; i++)  fv[i] = 16'd1;
        load_frame(1, xv, fv, 1'b0, 1'b0);
        collect(1, 9, 0, got, cnt, cl, rl);
        for (int j = 0; j < 9; j++) begin
            checks++;
            if (got[j] !== exp1[j]) begin
                errors++;
                $display("FAIL ramp_p4[%0d]: got %0d, required %0d", j, got[j], exp1[j]);
            end
        end
        checks++;
        if (rl !== 1'b0) begin
            errors++;
            $display("FAIL ramp_p4_ready_early: ready=%0b at last handshake, required 0", rl);
        end
        @(negedge clk);
        checks++;
        if (srx[1] !== 1'b1 || srf[1] !== 1'b1) begin
            errors++;
            $display("FAIL ramp_p4_ready_rise: x=%0b f=%0b, required 1 1", srx[1], srf[1]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mv[1] !== 1'b0) begin
                errors++;
                $display("FAIL ramp_p4_extra_out: valid=%0b after frame, required 0", mv[1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] xv[16], fv[8], got[16], eneg;
        int cnt, cl;
        bit rl;
`ifdef CONV1D_RELU_EN
        eneg = 16'h0000;
`else
        eneg = 16'h8000;
`endif
        for (int i = 0; i < 16; i++) xv[i] = 16'h7FFF;
        for (int i = 0; i < 8; i++)  fv[i] = 16'h7FFF;
        load_frame(0, xv, fv, 1'b0, 1'b0);
        collect(0, 9, 0, got, cnt, cl, rl);
        for (int j = 0; j < 9; j++) begin
            checks++;
            if (got[j] !== 16'h7FFF) begin
                errors++;
                $display("FAIL sat_pos[%0d]: got %h, required 7fff", j, got[j]);
            end
        end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) fv[i] = 16'h8000;
            load_frame(d, xv, fv, 1'b0, 1'b0);
            collect(d, 9, 0, got, cnt, cl, rl);
            for (int j = 0; j < 9; j++) begin
                checks++;
                if (got[j] !== eneg) begin
                    errors++;
                    $display("FAIL sat_neg dut%0d[%0d]: got %h, required %h", d, j, got[j], eneg);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] xv[16], fv[8], got[16], e;
        int ftab[8];
        int cnt, cl;
        bit rl;
        ftab = '{3, -2, 5, 1, -1, 4, -6, 2};
        for (int i = 0; i < 16; i++) xv[i] = 16'(i * 2500 - 18000);
        for (int i = 0; i < 8; i++)  fv[i] = 16'(ftab[i]);
        for (int d = 0; d < 2; d++) begin
            load_frame(d, xv, fv, 1'b1, 1'b1);
            collect(d, 9, 1, got, cnt, cl, rl);
            for (int j = 0; j < 9; j++) begin
                e = gold(xv, fv, j);
                checks++;
                if (got[j] !== e) begin
                    errors++;
                    $display("FAIL backpressure dut%0d[%0d]: got %h, required %h", d, j, got[j], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] xv[16], fv[8], got[16], e;
        int ftab[8];
        int cnt, cl, w;
        bit rl;
        for (int i = 0; i < 16; i++) xv[i] = 16'(i + 1);
        for (int i = 0; i < 8; i++)  fv[i] = 16'd1;
        load_frame(0, xv, fv, 1'b0, 1'b0);
        collect(0, 4, 0, got, cnt, cl, rl);
        @(negedge clk);
        mr[0] = 1'b0;
        w = 0;
        while (mv[0] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (mv[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reach_drain: valid=%0b, required 1", mv[0]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mv[0] !== 1'b0 || my[0] !== 16'h0) begin
            errors++;
            $display("FAIL midreset_out: valid=%0b data=%h, required 0 0000", mv[0], my[0]);
        end
        checks++;
        if (srx[0] !== 1'b1 || srf[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: x=%0b f=%0b, required 1 1", srx[0], srf[0]);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        ftab = '{3, -2, 5, 1, -1, 4, -6, 2};
        for (int i = 0; i < 16; i++) xv[i] = 16'(i * 2500 - 18000);
        for (int i = 0; i < 8; i++)  fv[i] = 16'(ftab[i]);
        load_frame(0, xv, fv, 1'b0, 1'b0);
        collect(0, 9, 0, got, cnt, cl, rl);
        for (int j = 0; j < 9; j++) begin
            e = gold(xv, fv, j);
            checks++;
            if (got[j] !== e) begin
                errors++;
                $display("FAIL after_reset[%0d]: got %h, required %h", j, got[j], e);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sdx[d] = 16'h0; svx[d] = 1'b0;
            sdf[d] = 16'h0; svf[d] = 1'b0;
            mr[d]  = 1'b0;
        end
        test_reset();
        test_ramp_p1();
        test_ramp_p4();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv1d_stream_par.md
Name: conv1d_stream_par

Overview:
Next-generation 1-D convolution engine (valid convolution, stride 1) with a runtime-loadable filter in place of a hard-wired filter ROM.
- Input vector arrives on a valid/ready slave stream; filter taps arrive on a second valid/ready slave stream.
- P parallel MAC lanes each compute one output per compute pass.
- Results leave serially on a valid/ready master stream.
- Sits between a layer input buffer and the next layer in the generated CNN pipeline.

Parameters:
T, 16, data width of x, f and y (signed two's complement)
X_COUNT, 16, input vector length
F_COUNT, 8, filter length; must satisfy 2 <= F_COUNT <= X_COUNT
P, 1, number of parallel MAC lanes; 1 <= P <= OP_COUNT
OP_COUNT, X_COUNT-F_COUNT+1, outputs per frame (derived; do not override)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
s_data_in_x  in  T  input sample
s_valid_x  in  1  input sample valid
s_ready_x  out  1  engine accepts input samples
s_data_in_f  in  T  filter tap, index 0 first
s_valid_f  in  1  filter tap valid
s_ready_f  out  1  engine accepts filter taps
m_data_out_y  out  T  output sample, index 0 first
m_valid_y  out  1  output valid
m_ready_y  in  1  downstream accepts output

Behaviour:
- Reset (reset low, asynchronous): state LOAD, all counters 0.
  - s_ready_x=1, s_ready_f=1, m_valid_y=0, m_data_out_y=0, accumulators 0.
  - Deassertion is synchronised internally, so no spurious transfers occur on the first clk after release.
- Transfers: a transfer occurs on a cycle with valid&ready high.
  - x and f streams load concurrently and independently into x_mem[X_COUNT] and f_mem[F_COUNT], at write addresses counting from 0.
  - Each ready drops the cycle after its last word is accepted.
- FSM states: LOAD -> COMPUTE -> DRAIN -> (COMPUTE | LOAD).
- LOAD: leave LOAD the cycle after both memories are full. Order and interleaving of the two streams are free.
- COMPUTE, group g, lanes k=0..P-1:
  - Lane k computes y[g*P+k] = sum over i of x[g*P+k+i]*f[i].
  - The memories present one tap per cycle to all lanes: the f read is shared, and x is read at base+k+i.
  - Pipeline: 1-cycle memory read, 1-cycle registered multiply.
  - COMPUTE lasts F_COUNT+2 cycles per group.
- Arithmetic:
  - Product is 2T bits, saturated to T bits: [-2^(T-1), 2^(T-1)-1].
  - Accumulator is T+1 bits; after each add, the value is re-saturated to the T-bit range before the next add.
- DRAIN:
  - m_valid_y=1; lanes are presented in order 0..P-1.
  - Lane index advances only on m_valid_y&m_ready_y.
  - m_data_out_y and m_valid_y hold stable while m_ready_y=0.
  - m_data_out_y=0 whenever m_valid_y=0.
- Last group: when OP_COUNT is not a multiple of P, only lanes with g*P+k < OP_COUNT are emitted; the others are computed and discarded.
- After the last handshake of a group:
  - If more groups remain: clear the accumulators and go to COMPUTE next cycle.
  - If the frame is complete: go to LOAD next cycle and raise s_ready_x and s_ready_f.
- No new frame data is accepted outside LOAD. Both memories are fully reloaded per frame.
- Reset mid-frame aborts the frame immediately with no partial output; the first frame after reset needs full reload.

Optional Feature:
- Macro: CONV1D_RELU_EN.
- Defined: each emitted value is max(y,0), applied after saturation.
- Undefined: the signed saturated value is emitted unchanged.
- The flag affects only the DRAIN output mux; timing is identical either way.

Decomposition:
- Package conv1d_pkg holds:
  - typedef state_t (LOAD, COMPUTE, DRAIN)
  - function sat_t(T+1 or 2T input -> T)
  - helper localparams for OP_COUNT and group count ceil(OP_COUNT/P)
- Sub-module conv1d_mac_lane:
  - Registered multiply, saturating accumulate, clear/enable.
  - Instantiated P times via generate.
- Memories are simple synchronous arrays inside the top module.

Test Plan:
1. x[i]=i+1 for i=0..15, f all 1, P=1, m_ready_y=1 -> 9 outputs: 36,44,52,...,100; frame completes in 9*(F_COUNT+2+1) cycles after load, ±2.
2. Same data with P=4 -> identical 9 values in order; group 3 emits exactly one value (100); s_ready_x/s_ready_f rise the cycle after its handshake.
3. x all 0x7FFF, f all 0x7FFF, macro undefined -> every output 0x7FFF (product and accumulator saturation); x all 0x7FFF, f all 0x8000 -> every output 0x8000.
4. Same negative-result stimulus with CONV1D_RELU_EN defined -> every output 0.
5. m_ready_y toggled in a 1,0,0,1 pattern with random stalls on s_valid_x/s_valid_f and f loaded before x -> output sequence matches the golden model; data stable during stalls.
6. reset pulsed low mid-DRAIN at output 4 -> m_valid_y=0 immediately, both readies=1; the next full frame produces a correct complete sequence.
